axi4_lite_sram_slave: RTL and testbench

- AXI4-Lite responder (slave end) backed by a word-addressed on-chip memory array with a programmable access latency.
- Serves the NPC core's fetch/LSU masters in simulation and early bring-up, and stands in for the real memory behind the AXI4-Lite master ports.
- Handles one transaction at a time: either a single read or a single write.
- Returns DECERR for addresses outside its window.

---
 rtl/axi4_lite_sram_slave.sv | 245 ++++++++++++++++++++++++
 tb/tb_axi4_lite_sram_slave.sv | 428 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/axi4_lite_sram_slave.sv
// -----------------------------------------------------------------------------
// axi4_lite_sram_slave
//
// AXI4-Lite responder backed by a word-addressed on-chip memory. One
// transaction (a single read or a single write) is in flight at a time. Each
// accepted address waits LATENCY extra cycles before its response is presented.
// Accesses outside [BASE_ADDR, BASE_ADDR + DEPTH*4) return DECERR, read as
// zero and never touch the memory.
//
// Ports
//   clk, rst_n                  clock, asynchronous active-low reset
//   araddr/arvalid/arready      read address channel
//   rdata/rresp/rvalid/rready   read data channel
//   awaddr/awvalid/awready      write address channel
//   wdata/wstrb/wvalid/wready   write data channel (AW and W accepted together)
//   bresp/bvalid/bready         write response channel
// -----------------------------------------------------------------------------
module axi4_lite_sram_slave #(
    parameter int                    ADDR_WIDTH = 32,
    parameter int                    DATA_WIDTH = 32,
    parameter logic [ADDR_WIDTH-1:0] BASE_ADDR  = 32'h8000_0000,
    parameter int                    DEPTH      = 4096,
    parameter int                    LATENCY    = 2
) (
    input  logic                  clk,
    input  logic                  rst_n,

    input  logic [ADDR_WIDTH-1:0] araddr,
    input  logic                  arvalid,
    output logic                  arready,
    output logic [DATA_WIDTH-1:0] rdata,
    output logic [1:0]            rresp,
    output logic                  rvalid,
    input  logic                  rready,

    input  logic [ADDR_WIDTH-1:0] awaddr,
    input  logic                  awvalid,
    output logic                  awready,
    input  logic [DATA_WIDTH-1:0] wdata,
    input  logic [3:0]            wstrb,
    input  logic                  wvalid,
    output logic                  wready,
    output logic [1:0]            bresp,
    output logic                  bvalid,
    input  logic                  bready
);

    // state   | meaning
    // --------+-------------------------------------------------------------
    // IDLE    | ready for a new address; read wins over a simultaneous write
    // RD_WAIT | read address latched, counting down the access latency
    // RD_RESP | rvalid high, rdata/rresp held until rready
    // WR_WAIT | write address/data latched, counting down the access latency
    // WR_RESP | write committed, bvalid high until bready

    typedef enum logic [2:0] {
        IDLE,
        RD_WAIT,
        RD_RESP,
        WR_WAIT,
        WR_RESP
    } state_t;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_DECERR = 2'b11;

    localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int AW1   = ADDR_WIDTH + 1;

    // Window bounds are held one bit wider than the address so that a window
    // ending exactly at 2^ADDR_WIDTH is representable and never wraps.
    localparam logic [AW1-1:0] WIN_LO = {1'b0, BASE_ADDR};
    localparam logic [AW1-1:0] WIN_HI = WIN_LO + AW1'(DEPTH) * AW1'(4);

    localparam logic [7:0] LAT8 = 8'(LATENCY);

    state_t                  state;
    state_t                  state_next;
    logic [7:0]              cnt;
    logic [7:0]              cnt_next;

    logic [ADDR_WIDTH-1:0]   addr_q;
    logic [DATA_WIDTH-1:0]   wdata_q;
    logic [3:0]              wstrb_q;

    logic [DATA_WIDTH-1:0]   mem [DEPTH];

    logic                    ar_hs;
    logic                    aw_hs;
    logic                    rd_load;
    logic                    wr_commit;
    logic                    in_range;
    logic [ADDR_WIDTH-1:0]   offset;
    logic [IDX_W-1:0]        idx;

    // -------------------------------------------------------------------------
    // Handshakes and ready outputs
    // -------------------------------------------------------------------------
    assign arready = (state == IDLE);
    assign awready = (state == IDLE) & awvalid & wvalid & ~arvalid;
    assign wready  = awready;

    assign ar_hs = arvalid & arready;
    assign aw_hs = awready;

    assign rvalid = (state == RD_RESP);
    assign bvalid = (state == WR_RESP);

    // -------------------------------------------------------------------------
    // Address decode of the latched address (shared by both directions, as
    // only one transaction is ever outstanding). addr[1:0] drops out in the
    // shift.
    // -------------------------------------------------------------------------
    assign in_range = ({1'b0, addr_q} >= WIN_LO) && ({1'b0, addr_q} < WIN_HI);
    assign offset   = addr_q - BASE_ADDR;
    assign idx      = IDX_W'(offset >> 2);

    // -------------------------------------------------------------------------
    // FSM: state register
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            cnt   <= 8'd0;
        end else begin
            state <= state_next;
            cnt   <= cnt_next;
        end
    end

    // -------------------------------------------------------------------------
    // FSM: next state, latency counter and datapath strobes
    // -------------------------------------------------------------------------
    always_comb begin
        state_next = state;
        cnt_next   = cnt;
        rd_load    = 1'b0;
        wr_commit  = 1'b0;

        case (state)
            IDLE: begin
                if (ar_hs) begin
                    state_next = RD_WAIT;
                    cnt_next   = LAT8;
                end else if (aw_hs) begin
                    state_next = WR_WAIT;
                    cnt_next   = LAT8;
                end
            end

            RD_WAIT: begin
                if (cnt == 8'd0) begin
                    state_next = RD_RESP;
                    rd_load    = 1'b1;
                end else begin
                    cnt_next = cnt - 8'd1;
                end
            end

            RD_RESP: begin
                if (rready) begin
                    state_next = IDLE;
                end
            end

            WR_WAIT: begin
                if (cnt == 8'd0) begin
                    state_next = WR_RESP;
                    wr_commit  = 1'b1;
                end else begin
                    cnt_next = cnt - 8'd1;
                end
            end

            WR_RESP: begin
                if (bready) begin
                    state_next = IDLE;
                end
            end

            default: begin
                state_next = IDLE;
                cnt_next   = 8'd0;
            end
        endcase
    end

    // -------------------------------------------------------------------------
    // Request capture
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            addr_q  <= '0;
            wdata_q <= '0;
            wstrb_q <= 4'h0;
        end else if (ar_hs) begin
            addr_q <= araddr;
        end else if (aw_hs) begin
            addr_q  <= awaddr;
            wdata_q <= wdata;
            wstrb_q <= wstrb;
        end
    end

    // -------------------------------------------------------------------------
    // Response registers: loaded once on entry to the RESP state and held
    // there, so the channel stays stable under backpressure.
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rdata <= '0;
            rresp <= RESP_OKAY;
            bresp <= RESP_OKAY;
        end else begin
            if (rd_load) begin
                rdata <= in_range ? mem[idx] : '0;
                rresp <= in_range ? RESP_OKAY : RESP_DECERR;
            end
            if (wr_commit) begin
                bresp <= in_range ? RESP_OKAY : RESP_DECERR;
            end
        end
    end

    // -------------------------------------------------------------------------
    // Memory array. Not reset: contents survive rst_n. A write interrupted by
    // reset never reaches wr_commit because the state register clears first.
    // -------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (wr_commit && in_range) begin
            for (int i = 0; i < 4; i++) begin
                if (wstrb_q[i]) begin
                    mem[idx][8*i +: 8] <= wdata_q[8*i +: 8];
                end
            end
        end
    end

    // The latency counter is 8 bits wide.
    always_ff @(posedge clk) begin
        assert (LATENCY >= 0 && LATENCY <= 255)
            else $error("axi4_lite_sram_slave: LATENCY out of range 0..255");
    end

endmodule

// File: tb/tb_axi4_lite_sram_slave.sv
// -----------------------------------------------------------------------------
// Testbench for axi4_lite_sram_slave.
// u_dut  (LATENCY=2): directed scenarios, then randomized master traffic, all
//                     checked every cycle against a transaction-level model.
// u_dut_b(LATENCY=4): reset asserted while a write is waiting.
// -----------------------------------------------------------------------------
module tb_axi4_lite_sram_slave;

    localparam int          AW    = 32;
    localparam int          DW    = 32;
    localparam int          DEPTH = 4096;
    localparam int          LAT   = 2;
    localparam int          LAT_B = 4;
    localparam logic [31:0] BASE  = 32'h8000_0000;

    localparam int S_ARREADY   = 0;
    localparam int S_AWREADY   = 1;
    localparam int S_RVALID    = 2;
    localparam int S_BVALID    = 3;
    localparam int S_ARREADY_B = 4;
    localparam int S_AWREADY_B = 5;
    localparam int S_RVALID_B  = 6;
    localparam int S_BVALID_B  = 7;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // main instance
    logic          rst_n;
    logic [AW-1:0] araddr, awaddr;
    logic          arvalid, arready, rvalid, rready;
    logic [DW-1:0] rdata, wdata;
    logic [1:0]    rresp, bresp;
    logic          awvalid, awready, wvalid, wready, bvalid, bready;
    logic [3:0]    wstrb;

    // reset-test instance
    logic          rst_n_b;
    logic [AW-1:0] araddr_b, awaddr_b;
    logic          arvalid_b, arready_b, rvalid_b, rready_b;
    logic [DW-1:0] rdata_b, wdata_b;
    logic [1:0]    rresp_b, bresp_b;
    logic          awvalid_b, awready_b, wvalid_b, wready_b, bvalid_b, bready_b;
    logic [3:0]    wstrb_b;

    axi4_lite_sram_slave #(
        .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .BASE_ADDR(BASE), .DEPTH(DEPTH), .LATENCY(LAT)
    ) u_dut (
        .clk(clk), .rst_n(rst_n),
        .araddr(araddr), .arvalid(arvalid), .arready(arready),
        .rdata(rdata), .rresp(rresp), .rvalid(rvalid), .rready(rready),
        .awaddr(awaddr), .awvalid(awvalid), .awready(awready),
        .wdata(wdata), .wstrb(wstrb), .wvalid(wvalid), .wready(wready),
        .bresp(bresp), .bvalid(bvalid), .bready(bready)
    );

    axi4_lite_sram_slave #(
        .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .BASE_ADDR(BASE), .DEPTH(DEPTH), .LATENCY(LAT_B)
    ) u_dut_b (
        .clk(clk), .rst_n(rst_n_b),
        .araddr(araddr_b), .arvalid(arvalid_b), .arready(arready_b),
        .rdata(rdata_b), .rresp(rresp_b), .rvalid(rvalid_b), .rready(rready_b),
        .awaddr(awaddr_b), .awvalid(awvalid_b), .awready(awready_b),
        .wdata(wdata_b), .wstrb(wstrb_b), .wvalid(wvalid_b), .wready(wready_b),
        .bresp(bresp_b), .bvalid(bvalid_b), .bready(bready_b)
    );

    int n_vec = 0;
    int n_bad = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // -------------------------------------------------------------------------
    // Reference model: a word memory plus "busy until cycle N" bookkeeping.
    // A request accepted at the edge after sample n produces a response visible
    // from sample n + 2 + LAT (entry to the response at T+1+LAT).
    // -------------------------------------------------------------------------
    logic [31:0] mref [int];
    bit          m_busy  = 1'b0;
    bit          m_rd    = 1'b0;
    bit          m_known = 1'b0;
    int          m_resp_n = 0;
    logic [31:0] m_rdata = 32'h0;
    logic [1:0]  m_resp  = 2'b00;
    int          ncyc    = 0;
    bit          in_resp;
    bit          e_awr;

    function automatic bit in_win(input logic [31:0] a);
        longint unsigned la, lb;
        la = a;
        lb = BASE;
        return (la >= lb) && (la < lb + longint'(DEPTH) * 4);
    endfunction

    function automatic int widx(input logic [31:0] a);
        return int'((a - BASE) >> 2);
    endfunction

    always @(negedge clk) begin
        if (!rst_n) begin
            chk("rst_arready", 32'(arready), 32'd1);
            chk("rst_rvalid",  32'(rvalid),  32'd0);
            chk("rst_bvalid",  32'(bvalid),  32'd0);
            chk("rst_rdata",   rdata,        32'd0);
            chk("rst_rresp",   32'(rresp),   32'd0);
            chk("rst_bresp",   32'(bresp),   32'd0);
            m_busy = 1'b0;
        end else begin
            in_resp = m_busy && (ncyc >= m_resp_n);
            e_awr   = !m_busy && awvalid && wvalid && !arvalid;
            chk("arready", 32'(arready), 32'(!m_busy));
            chk("awready", 32'(awready), 32'(e_awr));
            chk("wready",  32'(wready),  32'(e_awr));
            chk("rvalid",  32'(rvalid),  32'(in_resp && m_rd));
            chk("bvalid",  32'(bvalid),  32'(in_resp && !m_rd));
            if (in_resp && m_rd) begin
                if (m_known) chk("rdata", rdata, m_rdata);
                chk("rresp", 32'(rresp), 32'(m_resp));
            end
            if (in_resp && !m_rd) chk("bresp", 32'(bresp), 32'(m_resp));

            if (!m_busy) begin
                if (arvalid) begin
                    m_busy   = 1'b1;
                    m_rd     = 1'b1;
                    m_resp_n = ncyc + 2 + LAT;
                    if (in_win(araddr)) begin
                        m_resp  = 2'b00;
                        m_known = mref.exists(widx(araddr));
                        m_rdata = m_known ? mref[widx(araddr)] : 32'h0;
                    end else begin
                        m_resp  = 2'b11;
                        m_known = 1'b1;
                        m_rdata = 32'h0;
                    end
                end else if (awvalid && wvalid) begin
                    m_busy   = 1'b1;
                    m_rd     = 1'b0;
                    m_resp_n = ncyc + 2 + LAT;
                    if (in_win(awaddr)) begin
                        logic [31:0] w;
                        int k;
                        m_resp = 2'b00;
                        k = widx(awaddr);
                        if (mref.exists(k) || wstrb == 4'hF) begin
                            w = mref.exists(k) ? mref[k] : 32'h0;
                            for (int i = 0; i < 4; i++)
                                if (wstrb[i]) w[8*i +: 8] = wdata[8*i +: 8];
                            mref[k] = w;
                        end
                    end else begin
                        m_resp = 2'b11;
                    end
                end
            end else if (in_resp && (m_rd ? rready : bready)) begin
                m_busy = 1'b0;
            end
            ncyc++;
        end
    end

    // -------------------------------------------------------------------------
    // Stimulus helpers. Tasks start and end just after a rising edge.
    // -------------------------------------------------------------------------
    function automatic logic sig_sel(input int which);
        case (which)
            S_ARREADY:   return arready;
            S_AWREADY:   return awready;
            S_RVALID:    return rvalid;
            S_BVALID:    return bvalid;
            S_ARREADY_B: return arready_b;
            S_AWREADY_B: return awready_b;
            S_RVALID_B:  return rvalid_b;
            default:     return bvalid_b;
        endcase
    endfunction

    // Returns at the falling edge where the signal is seen high; cyc counts
    // rising edges passed while waiting.
    task automatic wait_for(input int which, input string name, output int cyc);
        cyc = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (sig_sel(which)) return;
            @(posedge clk);
            cyc++;
        end
        n_vec++;
        n_bad++;
        $display("FAIL timeout_%s: not asserted within 40 cycles, required asserted", name);
        cyc = -1;
    endtask

    task automatic do_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                            output int lat, output logic [1:0] resp);
        awaddr = a; wdata = d; wstrb = s; awvalid = 1'b1; wvalid = 1'b1; bready = 1'b1;
        wait_for(S_AWREADY, "awready", lat);
        @(posedge clk); #1;
        awvalid = 1'b0; wvalid = 1'b0;
        wait_for(S_BVALID, "bvalid", lat);
        resp = bresp;
        @(posedge clk); #1;
        bready = 1'b0;
    endtask

    task automatic do_read(input logic [31:0] a, output int lat,
                           output logic [31:0] d, output logic [1:0] resp);
        araddr = a; arvalid = 1'b1; rready = 1'b1;
        wait_for(S_ARREADY, "arready", lat);
        @(posedge clk); #1;
        arvalid = 1'b0;
        wait_for(S_RVALID, "rvalid", lat);
        d = rdata;
        resp = rresp;
        @(posedge clk); #1;
        rready = 1'b0;
    endtask

    function automatic logic [31:0] pick_addr();
        int r;
        r = $urandom_range(0, 19);
        if (r < 16)  return BASE + 32'(4 * r) + 32'($urandom_range(0, 3));
        if (r == 16) return BASE + 32'h3FFC;
        if (r == 17) return BASE + 32'h4000;
        if (r == 18) return BASE - 32'd4;
        return $urandom;
    endfunction

    // -------------------------------------------------------------------------
    // Main sequence
    // -------------------------------------------------------------------------
    initial begin
        int          lat;
        logic [31:0] d;
        logic [1:0]  rsp;
        bit          hs_ar, hs_w;

        rst_n = 1'b1; araddr = '0; arvalid = 1'b0; rready = 1'b0;
        awaddr = '0; awvalid = 1'b0; wdata = '0; wstrb = 4'h0; wvalid = 1'b0; bready = 1'b0;
        rst_n_b = 1'b1; araddr_b = '0; arvalid_b = 1'b0; rready_b = 1'b0;
        awaddr_b = '0; awvalid_b = 1'b0; wdata_b = '0; wstrb_b = 4'h0; wvalid_b = 1'b0; bready_b = 1'b0;
        #1;
        rst_n = 1'b0; rst_n_b = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1; rst_n_b = 1'b1;

        // write then read, latency check
        do_write(BASE + 32'h10, 32'hDEAD_BEEF, 4'hF, lat, rsp);
        chk("wr_latency", 32'(lat), 32'd3);
        chk("wr_bresp", 32'(rsp), 32'd0);
        do_read(BASE + 32'h10, lat, d, rsp);
        chk("rd_latency", 32'(lat), 32'd3);
        chk("rd_data", d, 32'hDEAD_BEEF);
        chk("rd_rresp", 32'(rsp), 32'd0);

        // partial strobes
        do_write(BASE, 32'h1122_3344, 4'hF, lat, rsp);
        do_write(BASE, 32'hAABB_CCDD, 4'b0101, lat, rsp);
        do_read(BASE, lat, d, rsp);
        chk("strb_data", d, 32'h11BB_33DD);

        // zero strobe commits nothing but answers OKAY
        do_write(BASE + 32'h10, 32'h0000_0000, 4'h0, lat, rsp);
        chk("strb0_bresp", 32'(rsp), 32'd0);
        do_read(BASE + 32'h12, lat, d, rsp);
        chk("strb0_data", d, 32'hDEAD_BEEF);

        // window edges
        do_read(32'h7FFF_FFFC, lat, d, rsp);
        chk("oor_rresp", 32'(rsp), 32'd3);
        chk("oor_rdata", d, 32'd0);
        do_write(32'h8000_4000, 32'h5555_AAAA, 4'hF, lat, rsp);
        chk("oor_bresp", 32'(rsp), 32'd3);
        do_read(BASE, lat, d, rsp);
        chk("oor_nowrite", d, 32'h11BB_33DD);
        do_write(BASE + 32'h3FFC, 32'hC0FF_EE01, 4'hF, lat, rsp);
        chk("last_bresp", 32'(rsp), 32'd0);
        do_read(BASE + 32'h3FFC, lat, d, rsp);
        chk("last_data", d, 32'hC0FF_EE01);
        chk("last_rresp", 32'(rsp), 32'd0);

        // contention and read backpressure
        araddr = BASE + 32'h10; arvalid = 1'b1; rready = 1'b0;
        awaddr = BASE + 32'h4; wdata = 32'h0BAD_CAFE; wstrb = 4'hF; awvalid = 1'b1; wvalid = 1'b1; bready = 1'b0;
        @(negedge clk);
        chk("cont_arready", 32'(arready), 32'd1);
        chk("cont_awready", 32'(awready), 32'd0);
        @(posedge clk); #1;
        arvalid = 1'b0;
        wait_for(S_RVALID, "rvalid", lat);
        chk("cont_rd_latency", 32'(lat), 32'd3);
        chk("cont_rdata", rdata, 32'hDEAD_BEEF);
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            @(negedge clk);
            chk("bp_rvalid", 32'(rvalid), 32'd1);
            chk("bp_rdata", rdata, 32'hDEAD_BEEF);
            chk("bp_arready", 32'(arready), 32'd0);
            chk("bp_awready", 32'(awready), 32'd0);
        end
        @(posedge clk); #1;
        rready = 1'b1;
        @(negedge clk);
        chk("bp_rvalid_hs", 32'(rvalid), 32'd1);
        @(posedge clk); #1;
        rready = 1'b0;
        @(negedge clk);
        chk("cont_wr_accept", 32'(awready), 32'd1);
        @(posedge clk); #1;
        awvalid = 1'b0; wvalid = 1'b0; bready = 1'b1;
        wait_for(S_BVALID, "bvalid", lat);
        chk("cont_wr_latency", 32'(lat), 32'd3);
        chk("cont_bresp", 32'(bresp), 32'd0);
        @(posedge clk); #1;
        bready = 1'b0;
        do_read(BASE + 32'h4, lat, d, rsp);
        chk("cont_wr_data", d, 32'h0BAD_CAFE);

        // AW without W
        awaddr = BASE + 32'h8; wdata = 32'h5A5A_1234; wstrb = 4'hF; awvalid = 1'b1; wvalid = 1'b0; bready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("split_awready", 32'(awready), 32'd0);
            chk("split_wready", 32'(wready), 32'd0);
            @(posedge clk); #1;
        end
        wvalid = 1'b1;
        @(negedge clk);
        chk("split_awready_go", 32'(awready), 32'd1);
        chk("split_wready_go", 32'(wready), 32'd1);
        @(posedge clk); #1;
        awvalid = 1'b0; wvalid = 1'b0;
        wait_for(S_BVALID, "bvalid", lat);
        @(posedge clk); #1;
        bready = 1'b0;
        do_read(BASE + 32'h8, lat, d, rsp);
        chk("split_data", d, 32'h5A5A_1234);

        // fill the random pool, then random traffic against the model
        for (int i = 0; i < 16; i++) do_write(BASE + 32'(4 * i), $urandom, 4'hF, lat, rsp);
        for (int c = 0; c < 3000; c++) begin
            @(negedge clk);
            hs_ar = arvalid && arready;
            hs_w  = awvalid && wvalid && awready;
            @(posedge clk); #1;
            if (!arvalid || hs_ar) begin
                arvalid = ($urandom_range(0, 99) < 25);
                araddr  = pick_addr();
            end
            if (hs_w) begin
                awvalid = 1'b0;
                wvalid  = 1'b0;
            end
            if (!awvalid && $urandom_range(0, 99) < 30) begin
                awvalid = 1'b1;
                awaddr  = pick_addr();
            end
            if (!wvalid && $urandom_range(0, 99) < 30) begin
                wvalid = 1'b1;
                wdata  = $urandom;
                wstrb  = 4'($urandom_range(0, 15));
            end
            rready = ($urandom_range(0, 99) < 60);
            bready = ($urandom_range(0, 99) < 60);
        end
        arvalid = 1'b0; awvalid = 1'b0; wvalid = 1'b0; rready = 1'b1; bready = 1'b1;
        repeat (20) @(posedge clk);
        #1;
        rready = 1'b0; bready = 1'b0;

        // reset during WR_WAIT on the LATENCY=4 instance
        awaddr_b = BASE + 32'h20; wdata_b = 32'h0BAD_F00D; wstrb_b = 4'hF;
        awvalid_b = 1'b1; wvalid_b = 1'b1; bready_b = 1'b1;
        wait_for(S_AWREADY_B, "awready_b", lat);
        @(posedge clk); #1;
        awvalid_b = 1'b0; wvalid_b = 1'b0;
        wait_for(S_BVALID_B, "bvalid_b", lat);
        chk("b_wr_latency", 32'(lat), 32'd5);
        chk("b_bresp", 32'(bresp_b), 32'd0);
        @(posedge clk); #1;
        bready_b = 1'b0;

        wdata_b = 32'hFFFF_FFFF; awvalid_b = 1'b1; wvalid_b = 1'b1; bready_b = 1'b1;
        wait_for(S_AWREADY_B, "awready_b", lat);
        @(posedge clk); #1;
        awvalid_b = 1'b0; wvalid_b = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst_n_b = 1'b0;
        #1;
        chk("b_rst_rvalid", 32'(rvalid_b), 32'd0);
        chk("b_rst_bvalid", 32'(bvalid_b), 32'd0);
        chk("b_rst_arready", 32'(arready_b), 32'd1);
        repeat (2) @(posedge clk);
        #1;
        rst_n_b = 1'b1;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            chk("b_post_arready", 32'(arready_b), 32'd1);
            chk("b_post_bvalid", 32'(bvalid_b), 32'd0);
        end
        @(posedge clk); #1;
        bready_b = 1'b0;
        araddr_b = BASE + 32'h20; arvalid_b = 1'b1; rready_b = 1'b1;
        wait_for(S_ARREADY_B, "arready_b", lat);
        @(posedge clk); #1;
        arvalid_b = 1'b0;
        wait_for(S_RVALID_B, "rvalid_b", lat);
        chk("b_rd_latency", 32'(lat), 32'd5);
        chk("b_rd_data", rdata_b, 32'h0BAD_F00D);
        chk("b_rd_rresp", 32'(rresp_b), 32'd0);
        @(posedge clk); #1;
        rready_b = 1'b0;
        repeat (2) @(posedge clk);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
